param_adder_accumulator: RTL and testbench

Parametrised successor to the board-level adder/accumulator core. It accumulates a switch-loaded operand into a wide register on button presses, and adds subtract, clear, a selectable wrap/saturate mode, a sticky overflow flag and an operation counter. It exposes a byte-wide registered display mux for the seven-segment driver. It sits between the raw board I/O (switches, buttons) and the display/LED logic, all in the MCLK domain.

---
 rtl/param_adder_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_param_adder_accumulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_adder_accumulator.sv
// -----------------------------------------------------------------------------
// param_adder_accumulator
//
// Button-driven adder/accumulator. An operand is loaded from the switches.
// Add and subtract presses fold the operand into a wide accumulator. Each
// press can either wrap or saturate. A sticky flag records any carry or
// borrow, and a counter tracks executed add/sub operations. A registered
// byte mux feeds the seven-segment driver.
//
// Ports
//   MCLK       in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sw         in   [DATA_W]  operand value, captured when load executes
//   btn_clear  in   raw button: acc, count, ovf <- 0
//   btn_load   in   raw button: operand <- sw
//   btn_add    in   raw button: acc <- acc + operand
//   btn_sub    in   raw button: acc <- acc - operand
//   mux_sel    in   [3]  display source select
//   acc        out  [ACC_W]  accumulator
//   operand    out  [DATA_W] operand register
//   count      out  [CNT_W]  executed add/sub operations (wraps)
//   ovf        out  sticky overflow/underflow flag
//   disp       out  [8]  registered display byte
// -----------------------------------------------------------------------------
module param_adder_accumulator #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic              MCLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_clear,
  input  logic              btn_load,
  input  logic              btn_add,
  input  logic              btn_sub,
  input  logic [2:0]        mux_sel,
  output logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] operand,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic [7:0]        disp
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLEAR,
    OP_LOAD,
    OP_SUB,
    OP_ADD
  } op_e;

  // Bit positions inside the button vectors.
  localparam int B_CLEAR = 0;
  localparam int B_LOAD  = 1;
  localparam int B_SUB   = 2;
  localparam int B_ADD   = 3;

  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] edge_q,  edge_d;
  logic [3:0] pulse;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        disp_q, disp_d;

  op_e              op;
  logic [ACC_W:0]   operand_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             carry;
  logic             borrow;

  assign btn_raw = {btn_add, btn_sub, btn_load, btn_clear};

  // Two synchroniser stages, then a third flop that holds the previous level.
  // A press gives one pulse on the cycle where the synchronised level first
  // reads high.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  assign pulse = sync2_q & ~edge_q;

  // Only one operation runs per cycle. Lower-priority pulses in the same
  // cycle are dropped.
  always_comb begin
    op = OP_NONE;
    if      (pulse[B_CLEAR]) op = OP_CLEAR;
    else if (pulse[B_LOAD])  op = OP_LOAD;
    else if (pulse[B_SUB])   op = OP_SUB;
    else if (pulse[B_ADD])   op = OP_ADD;
  end

  // One extra bit on the left captures the carry out, or the borrow as a
  // negative result. Both operands are below 2^ACC_W, so that top bit is
  // exact.
  assign operand_ext = (ACC_W+1)'(operand_q);
  assign sum         = {1'b0, acc_q} + operand_ext;
  assign diff        = {1'b0, acc_q} - operand_ext;
  assign carry       = sum[ACC_W];
  assign borrow      = diff[ACC_W];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case tree can leave a value unassigned and infer a
  // latch.
  always_comb begin
    acc_d     = acc_q;
    operand_d = operand_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unique case (op)
      OP_CLEAR: begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
      OP_LOAD: operand_d = sw;
      OP_ADD: begin
        acc_d   = (SATURATE != 0 && carry) ? '1 : sum[ACC_W-1:0];
        ovf_d   = ovf_q | carry;
        count_d = count_q + CNT_W'(1);
      end
      OP_SUB: begin
        acc_d   = (SATURATE != 0 && borrow) ? '0 : diff[ACC_W-1:0];
        ovf_d   = ovf_q | borrow;
        count_d = count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // The display shows registered state, so it trails acc, operand and count
  // by one cycle.
  always_comb begin
    disp_d = 8'h00;
    if (mux_sel == 3'd6) begin
      disp_d = 8'(operand_q);
    end else if (mux_sel == 3'd7) begin
      disp_d = count_q[7:0];
    end else begin
      for (int k = 0; k < ACC_W / 8; k++) begin
        if (mux_sel == 3'(k)) disp_d = acc_q[8*k +: 8];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops then
  // sample their inputs from the same pre-edge values, whatever order the
  // simulator runs the statements in.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      edge_q    <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      edge_q    <= edge_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
    end
  end

  assign acc     = acc_q;
  assign operand = operand_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign disp    = disp_q;

endmodule

// File: tb/tb_param_adder_accumulator.sv
// -----------------------------------------------------------------------------
// tb_param_adder_accumulator
//
// Drives two instances from the same stimulus: one wraps (SATURATE=0) and one
// clamps (SATURATE=1). A plain-arithmetic reference model tracks both
// accumulators, the shared operand and the shared counter.
// -----------------------------------------------------------------------------
module tb_param_adder_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;
  localparam longint ACC_MOD = longint'(1) << ACC_W;
  localparam longint CNT_MOD = longint'(1) << CNT_W;

  logic              MCLK = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] sw;
  logic              btn_clear, btn_load, btn_add, btn_sub;
  logic [2:0]        mux_sel;

  logic [ACC_W-1:0]  acc0, acc1;
  logic [DATA_W-1:0] operand0, operand1;
  logic [CNT_W-1:0]  count0, count1;
  logic              ovf0, ovf1;
  logic [7:0]        disp0, disp1;

  param_adder_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)
  ) dut_wrap (
    .MCLK(MCLK), .rst_n(rst_n), .sw(sw),
    .btn_clear(btn_clear), .btn_load(btn_load), .btn_add(btn_add), .btn_sub(btn_sub),
    .mux_sel(mux_sel),
    .acc(acc0), .operand(operand0), .count(count0), .ovf(ovf0), .disp(disp0)
  );

  param_adder_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)
  ) dut_sat (
    .MCLK(MCLK), .rst_n(rst_n), .sw(sw),
    .btn_clear(btn_clear), .btn_load(btn_load), .btn_add(btn_add), .btn_sub(btn_sub),
    .mux_sel(mux_sel),
    .acc(acc1), .operand(operand1), .count(count1), .ovf(ovf1), .disp(disp1)
  );

  always #5 MCLK = ~MCLK;

  // Reference model state.
  longint m_acc_wrap, m_acc_sat, m_op, m_cnt;
  bit     m_ovf_wrap, m_ovf_sat;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input longint observed, input longint expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic model_reset();
    m_acc_wrap = 0; m_acc_sat = 0; m_op = 0; m_cnt = 0;
    m_ovf_wrap = 0; m_ovf_sat = 0;
  endtask

  // mask bits: 0 clear, 1 load, 2 sub, 3 add. Only the highest priority runs.
  task automatic model_apply(input logic [3:0] mask);
    longint s;
    if (mask[0]) begin
      m_acc_wrap = 0; m_acc_sat = 0; m_cnt = 0; m_ovf_wrap = 0; m_ovf_sat = 0;
    end else if (mask[1]) begin
      m_op = longint'(sw);
    end else if (mask[2]) begin
      if (m_op > m_acc_wrap) m_ovf_wrap = 1;
      m_acc_wrap = (m_acc_wrap - m_op + ACC_MOD) % ACC_MOD;
      if (m_op > m_acc_sat) begin
        m_ovf_sat = 1; m_acc_sat = 0;
      end else m_acc_sat = m_acc_sat - m_op;
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end else if (mask[3]) begin
      s = m_acc_wrap + m_op;
      if (s >= ACC_MOD) m_ovf_wrap = 1;
      m_acc_wrap = s % ACC_MOD;
      s = m_acc_sat + m_op;
      if (s >= ACC_MOD) begin
        m_ovf_sat = 1; m_acc_sat = ACC_MOD - 1;
      end else m_acc_sat = s;
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
  endtask

  function automatic longint disp_exp(input longint accv);
    int sel = int'(mux_sel);
    if (sel < ACC_W / 8) return (accv >> (8 * sel)) & 255;
    if (sel == 6) return m_op & 255;
    if (sel == 7) return m_cnt & 255;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".acc_wrap"}, acc0, m_acc_wrap);
    check({tag, ".acc_sat"},  acc1, m_acc_sat);
    check({tag, ".ovf_wrap"}, ovf0, m_ovf_wrap);
    check({tag, ".ovf_sat"},  ovf1, m_ovf_sat);
    check({tag, ".count"},    count0, m_cnt);
    check({tag, ".count_s"},  count1, m_cnt);
    check({tag, ".operand"},  operand0, m_op);
    check({tag, ".disp_wrap"}, disp0, disp_exp(m_acc_wrap));
    check({tag, ".disp_sat"},  disp1, disp_exp(m_acc_sat));
  endtask

  // One press: buttons high for 'hold' cycles, then low long enough for the
  // result and the display to settle before the model is updated.
  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge MCLK);
    {btn_add, btn_sub, btn_load, btn_clear} = mask;
    repeat (hold) @(negedge MCLK);
    {btn_add, btn_sub, btn_load, btn_clear} = 4'b0000;
    repeat (3) @(negedge MCLK);
    model_apply(mask);
  endtask

  localparam logic [3:0] M_CLEAR = 4'b0001;
  localparam logic [3:0] M_LOAD  = 4'b0010;
  localparam logic [3:0] M_SUB   = 4'b0100;
  localparam logic [3:0] M_ADD   = 4'b1000;

  initial begin
    logic [3:0] mask;
    rst_n = 1'b0;
    sw = '0; mux_sel = 3'd0;
    {btn_add, btn_sub, btn_load, btn_clear} = 4'b0000;
    model_reset();
    repeat (3) @(negedge MCLK);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge MCLK);

    // Load 2, then 300 adds.
    sw = 8'd2;
    press(M_LOAD, 1);
    repeat (300) press(M_ADD, 1);
    check_all("add300");
    check("add300.acc_const", acc0, 600);
    check("add300.disp_lo", disp0, 8'h58);
    check("add300.count_const", count0, 8'h2C);
    check("add300.ovf_const", ovf0, 0);
    mux_sel = 3'd1;
    repeat (2) @(negedge MCLK);
    check("add300.disp_hi", disp0, 8'h02);
    mux_sel = 3'd7;
    repeat (2) @(negedge MCLK);
    check("add300.disp_cnt", disp0, 8'h2C);

    // Wrap vs saturate on overflow.
    press(M_CLEAR, 1);
    sw = 8'hFF;
    press(M_LOAD, 2);
    mux_sel = 3'd0;
    repeat (258) press(M_ADD, 1);
    check_all("wrap");
    check("wrap.acc_const", acc0, 254);
    check("wrap.sat_const", acc1, 16'hFFFF);
    check("wrap.ovf_const", ovf0, 1);
    press(M_CLEAR, 1);
    check_all("wrap_clear");
    check("wrap_clear.acc", acc0, 0);
    check("wrap_clear.ovf", ovf0, 0);

    // Underflow: acc=3 minus 5.
    sw = 8'd3; press(M_LOAD, 1);
    press(M_ADD, 1);
    sw = 8'd5; press(M_LOAD, 1);
    press(M_SUB, 1);
    check_all("underflow");
    check("underflow.sat_acc", acc1, 0);
    check("underflow.sat_ovf", ovf1, 1);
    check("underflow.wrap_acc", acc0, 16'hFFFE);

    // Saturate at the top: acc=FFFE plus 5.
    press(M_CLEAR, 1);
    sw = 8'hFF; press(M_LOAD, 1);
    repeat (256) press(M_ADD, 1);
    sw = 8'hFE; press(M_LOAD, 1);
    press(M_ADD, 1);
    check_all("fffe");
    check("fffe.acc", acc1, 16'hFFFE);
    check("fffe.ovf", ovf1, 0);
    sw = 8'd5; press(M_LOAD, 1);
    press(M_ADD, 1);
    check_all("sat_top");
    check("sat_top.acc", acc1, 16'hFFFF);
    check("sat_top.ovf", ovf1, 1);

    // Simultaneous presses.
    sw = 8'd7;
    press(M_LOAD | M_ADD, 1);
    check_all("load_add");
    check("load_add.operand", operand0, 7);
    press(M_CLEAR | M_ADD, 1);
    check_all("clear_add");
    check("clear_add.acc", acc0, 0);
    check("clear_add.count", count0, 0);

    // Held button: one pulse only, with exact latency.
    sw = 8'd3; press(M_LOAD, 1);
    mux_sel = 3'd0;
    @(negedge MCLK);
    btn_add = 1'b1;
    @(negedge MCLK);
    check("held.after_e0", acc0, 0);
    @(negedge MCLK);
    check("held.after_e1", acc0, 0);
    @(negedge MCLK);
    check("held.after_e2", acc0, 3);
    check("held.disp_old", disp0, 0);
    @(negedge MCLK);
    check("held.disp_new", disp0, 3);
    repeat (46) @(negedge MCLK);
    btn_add = 1'b0;
    repeat (3) @(negedge MCLK);
    model_apply(M_ADD);
    check_all("held");
    check("held.acc_final", acc0, 3);

    // Randomised operations.
    for (int i = 0; i < 200; i++) begin
      mask = 4'($urandom);
      if (mask[0] && $urandom_range(0, 3) != 0) mask[0] = 1'b0;
      sw = 8'($urandom);
      mux_sel = 3'($urandom);
      press(mask, int'($urandom_range(1, 3)));
      check_all($sformatf("rand%0d", i));
    end

    // Reset during the pulse cycle of an add.
    mux_sel = 3'd0;
    press(M_CLEAR, 1);
    sw = 8'd10; press(M_LOAD, 1);
    press(M_ADD, 1);
    check("rstmid.setup", acc0, 10);
    @(negedge MCLK);
    btn_add = 1'b1;
    @(negedge MCLK);
    @(negedge MCLK);
    rst_n = 1'b0;
    btn_add = 1'b0;
    #1;
    check("rstmid.acc_now", acc0, 0);
    check("rstmid.acc_sat_now", acc1, 0);
    model_reset();
    repeat (2) @(negedge MCLK);
    rst_n = 1'b1;
    repeat (5) @(negedge MCLK);
    check_all("rstmid_after");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
